load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the core datapath and `data_memory`. Converts byte, halfword and word load/store requests into the word-only read/write accesses the data memory supports. Loads use little-endian lane extraction with optional sign extension. Sub-word stores run as a two-cycle read-modify-write, and the core is back-pressured through a ready/valid handshake.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: word width. Only 32 is supported.

Ports (clock and reset first):
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `req_valid` input 1: core request present.
- `req_ready` output 1: unit can accept a request this cycle.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_signed` input 1: sign-extend sub-word loads. Ignored for stores.
- `req_addr` input ADDR_W: byte address.
- `req_wdata` input DATA_W: store data, taken from the low-order bits.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output DATA_W: load result. 0 for stores.
- `resp_err` output 1: misaligned access, qualified by `resp_valid`.
- `mem_read_flag` output 1: connects to `data_memory`.
- `mem_write_flag` output 1: connects to `data_memory`.
- `mem_addr` output ADDR_W: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata` output DATA_W: write data to memory.
- `mem_rdata` input DATA_W: asynchronous read data from memory.

## Operation
- States: IDLE and RMW_WR. `req_ready = (state==IDLE) && !rst`. A request is accepted when `req_valid && req_ready`.
- Byte lanes:
  - Byte k = `addr[1:0]` occupies bits [8k+7:8k].
  - Half uses `addr[1]`: 0 selects [15:0], 1 selects [31:16].
- Load, any size, accepted in IDLE:
  - Same cycle: `mem_read_flag=1` and the aligned `mem_addr` are driven.
  - The lane is extracted from `mem_rdata`, zero- or sign-extended, and registered into `resp_rdata`.
  - State stays IDLE.
- Word store accepted in IDLE:
  - Same cycle: `mem_write_flag=1`, `mem_wdata=req_wdata`.
  - State stays IDLE.
- Sub-word store accepted in IDLE:
  - Accept cycle: `mem_read_flag=1`. The addressed lane of `mem_rdata` is replaced with `req_wdata` low bits. The merged word and aligned address are latched, and the state goes to RMW_WR.
  - RMW_WR cycle: `mem_write_flag=1`, `mem_addr`/`mem_wdata` driven from the latches, `req_ready=0`. The state returns to IDLE.
- `mem_read_flag` and `mem_write_flag` are never high together. Both are 0 in IDLE when no request is accepted, and both are 0 whenever `rst=1`.
- Misaligned access: half with `addr[0]=1`, or word with `addr[1:0]≠0`. Handling is set by the macro in Configuration.

## Timing
- Reset values: state IDLE, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, latches 0.
- Reset in RMW_WR abandons the write. No memory write occurs in the reset cycle.
- Load and word-store latency: `resp_valid` rises 1 cycle after accept.
- Sub-word store latency: `resp_valid` rises 2 cycles after accept, i.e. the cycle after RMW_WR.
- Throughput:
  - Loads and word stores: one per cycle, back-to-back.
  - Sub-word stores: one every 2 cycles.
- `resp_valid` is a 1-cycle pulse. `resp_rdata` holds its value until the next response.
- Accept cycle back-to-back with RMW_WR: not possible, because `req_ready=0` in RMW_WR.
- A store's write commits at the clock edge ending its write cycle. A load accepted the next cycle reads the new value.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a misaligned request is accepted with no memory access. The next cycle gives `resp_valid=1`, `resp_err=1`, `resp_rdata=0`.
- `LSU_MISALIGN_TRAP_EN` undefined: offending low address bits are ignored.
  - Half uses `addr[1]` only.
  - Word uses `addr[31:2]`.
  - `resp_err` is tied to 0.

## Structure
- Package `lsu_pkg`:
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - State encodings `ST_IDLE`, `ST_RMW_WR`.
  - Lane-select helper constants.
- Sub-module `lsu_align`: combinational lane extract/sign-extend for loads and lane merge for stores. The FSM and registers stay in `load_store_unit`.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 → `resp_rdata=0xDEADBEEF`, each `resp_valid` 1 cycle after accept.
- Memory word @0x20 = 0x8070F0FF:
  - signed byte load @0x21 → 0xFFFFFFF0.
  - unsigned byte load @0x21 → 0x000000F0.
  - signed half @0x22 → 0xFFFF8070.
- Byte store 0xAB @0x23 over 0x11223344:
  - `req_ready` is low for 1 cycle.
  - Memory becomes 0xAB223344.
  - `resp_valid` is seen 2 cycles after accept.
- Half store 0x5566 @0x12 followed immediately by a load request → load stalled 1 cycle, then returns the merged word.
- Word load @0x06 with the macro defined → `resp_err=1`, `resp_rdata=0`, no `mem_read_flag`. With the macro undefined → data of word @0x04, `resp_err=0`.
- Assert `rst` during RMW_WR → no `mem_write_flag` that cycle. After reset, `resp_valid=0` and `req_ready=1`.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } lsu_state_e;

  localparam int         NUM_LANES  = 4;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic is_subword(input logic [1:0] sz);
    return (sz == SZ_BYTE) || (sz == SZ_HALF);
  endfunction

  // Size 11 behaves as a word, so anything that is not byte/half needs full alignment.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    if (sz == SZ_BYTE) return 1'b0;
    if (sz == SZ_HALF) return off[0];
    return off != 2'b00;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response and data-memory signals of the load/store unit.
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_read_flag;
  logic              mem_write_flag;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read_flag, mem_write_flag, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read_flag, mem_write_flag, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: little-endian load extract/extend and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [1:0]        i_off,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load_data,
  output logic [DATA_W-1:0] o_merged
);

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wrep;

  always_comb begin
    w_byte = i_rdata[8*i_off +: 8];
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SZ_BYTE: o_load_data = {{(DATA_W-8){i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_load_data = {{(DATA_W-16){i_signed & w_half[15]}}, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

  // Replicate store data across lanes so each lane only needs a byte-enable mux.
  always_comb begin
    case (i_size)
      SZ_BYTE: begin
        w_be   = BE_BYTE0 << i_off;
        w_wrep = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be   = i_off[1] ? BE_HALF_HI : BE_HALF_LO;
        w_wrep = {2{i_wdata[15:0]}};
      end
      default: begin
        w_be   = BE_WORD;
        w_wrep = i_wdata;
      end
    endcase
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign o_merged[8*k +: 8] = w_be[k] ? w_wrep[8*k +: 8] : i_rdata[8*k +: 8];
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-only data memory; sub-word stores use RMW.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned requests with resp_err.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  lsu_state_e        r_state, w_next;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_ready;
  logic              w_accept;
  logic              w_mis;
  logic              w_rmw;
  logic [ADDR_W-1:0] w_aligned;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_merged;

  assign w_ready   = (r_state == ST_IDLE) && !rst;
  assign w_accept  = bus.req_valid && w_ready;
  assign w_aligned = {bus.req_addr[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  assign w_rmw = bus.req_write && is_subword(bus.req_size) && !w_mis;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .i_size      (bus.req_size),
    .i_signed    (bus.req_signed),
    .i_off       (bus.req_addr[1:0]),
    .i_rdata     (bus.mem_rdata),
    .i_wdata     (bus.req_wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept && w_rmw) w_next = ST_RMW_WR;
      ST_RMW_WR: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready      = w_ready;
    bus.mem_read_flag  = 1'b0;
    bus.mem_write_flag = 1'b0;
    bus.mem_addr       = w_aligned;
    bus.mem_wdata      = bus.req_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_mis) begin
          if (!bus.req_write || w_rmw) bus.mem_read_flag  = 1'b1;
          else                         bus.mem_write_flag = 1'b1;
        end
      end
      ST_RMW_WR: begin
        // Reset in this cycle drops the pending write.
        bus.mem_write_flag = !rst;
        bus.mem_addr       = r_wr_addr;
        bus.mem_wdata      = r_wr_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (r_state == ST_RMW_WR) begin
        r_resp_valid <= 1'b1;
        r_resp_rdata <= '0;
        r_resp_err   <= 1'b0;
      end else if (w_accept) begin
        if (w_rmw) begin
          r_wr_addr <= w_aligned;
          r_wr_data <= w_merged;
        end else begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= (bus.req_write || w_mis) ? '0 : w_load_data;
          r_resp_err   <= w_mis;
        end
      end
    end
  end

  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word-only data memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:63];
  always @(posedge clk) if (bus.mem_write_flag) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] d);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = d;
  endtask

  task automatic noreq();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    noreq();
    rst = 1'b1;
    tick(); tick();
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_resp_err",   bus.resp_err,   1'b0);
    check("rst_req_ready",  bus.req_ready,  1'b0);
    check("rst_rd_flag",    bus.mem_read_flag,  1'b0);
    check("rst_wr_flag",    bus.mem_write_flag, 1'b0);
    rst = 1'b0;
    #1;
    check("idle_req_ready", bus.req_ready, 1'b1);
    check("idle_rd_flag",   bus.mem_read_flag,  1'b0);
    check("idle_wr_flag",   bus.mem_write_flag, 1'b0);

    // word store then word load back-to-back
    req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
    #1;
    check("wst_wr_flag", bus.mem_write_flag, 1'b1);
    check("wst_rd_flag", bus.mem_read_flag,  1'b0);
    check("wst_addr",    bus.mem_addr,  32'h10);
    check("wst_wdata",   bus.mem_wdata, 32'hDEADBEEF);
    tick();
    check("wst_resp_valid", bus.resp_valid, 1'b1);
    check("wst_resp_rdata", bus.resp_rdata, 32'h0);
    check("wst_resp_err",   bus.resp_err,   1'b0);
    req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    #1;
    check("wld_rd_flag", bus.mem_read_flag,  1'b1);
    check("wld_wr_flag", bus.mem_write_flag, 1'b0);
    tick();
    check("wld_resp_valid", bus.resp_valid, 1'b1);
    check("wld_resp_rdata", bus.resp_rdata, 32'hDEADBEEF);
    noreq();
    tick();
    check("pulse_low",  bus.resp_valid, 1'b0);
    check("rdata_hold", bus.resp_rdata, 32'hDEADBEEF);

    // lane extraction from 0x8070F0FF @0x20
    req(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h8070F0FF); tick();
    req(1'b0, SZ_BYTE, 1'b1, 32'h21, 32'h0); tick();
    check("lb_signed_v", bus.resp_valid, 1'b1);
    check("lb_signed",   bus.resp_rdata, 32'hFFFFFFF0);
    req(1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0); tick();
    check("lb_unsigned", bus.resp_rdata, 32'h000000F0);
    req(1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0); tick();
    check("lh_signed",   bus.resp_rdata, 32'hFFFF8070);
    req(1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0); tick();
    check("lh_unsigned", bus.resp_rdata, 32'h0000F0FF);
    req(1'b0, SZ_BYTE, 1'b1, 32'h23, 32'h0); tick();
    check("lb_signed_hi", bus.resp_rdata, 32'hFFFFFF80);
    req(1'b0, 2'b11, 1'b1, 32'h20, 32'h0); tick();
    check("size11_word", bus.resp_rdata, 32'h8070F0FF);

    // byte store RMW: 0xAB @0x23 over 0x11223344
    req(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344); tick();
    req(1'b1, SZ_BYTE, 1'b0, 32'h23, 32'hFFFFFFAB);
    #1;
    check("sb_rd_flag",   bus.mem_read_flag,  1'b1);
    check("sb_wr_flag0",  bus.mem_write_flag, 1'b0);
    check("sb_ready_acc", bus.req_ready, 1'b1);
    tick();
    noreq();
    #1;
    check("sb_ready_rmw", bus.req_ready, 1'b0);
    check("sb_wr_flag1",  bus.mem_write_flag, 1'b1);
    check("sb_rd_flag1",  bus.mem_read_flag,  1'b0);
    check("sb_wr_addr",   bus.mem_addr,  32'h20);
    check("sb_wr_data",   bus.mem_wdata, 32'hAB223344);
    check("sb_no_resp",   bus.resp_valid, 1'b0);
    tick();
    check("sb_resp_valid", bus.resp_valid, 1'b1);
    check("sb_resp_rdata", bus.resp_rdata, 32'h0);
    check("sb_ready_back", bus.req_ready,  1'b1);
    check("sb_mem",        mem[8], 32'hAB223344);
    req(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0); tick();
    check("sb_readback", bus.resp_rdata, 32'hAB223344);

    // half store 0x5566 @0x12 with a load queued right behind it
    req(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h00005566); tick();
    req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    #1;
    check("sh_stall_ready", bus.req_ready, 1'b0);
    check("sh_stall_rd",    bus.mem_read_flag, 1'b0);
    tick();
    check("sh_resp_valid",  bus.resp_valid, 1'b1);
    check("sh_ld_ready",    bus.req_ready, 1'b1);
    check("sh_ld_rd",       bus.mem_read_flag, 1'b1);
    tick();
    check("sh_ld_valid",    bus.resp_valid, 1'b1);
    check("sh_ld_rdata",    bus.resp_rdata, 32'h5566BEEF);
    noreq();

    // misaligned accesses
    req(1'b1, SZ_WORD, 1'b0, 32'h04, 32'hCAFEF00D); tick();
    req(1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0);
    #1;
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_w_rd", bus.mem_read_flag, 1'b0);
    tick();
    check("mis_w_valid", bus.resp_valid, 1'b1);
    check("mis_w_err",   bus.resp_err,   1'b1);
    check("mis_w_rdata", bus.resp_rdata, 32'h0);
    req(1'b0, SZ_HALF, 1'b0, 32'h05, 32'h0); tick();
    check("mis_h_err",   bus.resp_err,   1'b1);
    check("mis_h_rdata", bus.resp_rdata, 32'h0);
`else
    check("mis_w_rd",   bus.mem_read_flag, 1'b1);
    check("mis_w_addr", bus.mem_addr, 32'h04);
    tick();
    check("mis_w_valid", bus.resp_valid, 1'b1);
    check("mis_w_err",   bus.resp_err,   1'b0);
    check("mis_w_rdata", bus.resp_rdata, 32'hCAFEF00D);
    req(1'b0, SZ_HALF, 1'b0, 32'h07, 32'h0); tick();
    check("mis_h_err",   bus.resp_err,   1'b0);
    check("mis_h_rdata", bus.resp_rdata, 32'h0000CAFE);
`endif
    noreq();
    tick();

    // reset while in RMW_WR abandons the write
    req(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h01020304); tick();
    req(1'b1, SZ_BYTE, 1'b0, 32'h30, 32'h00000077); tick();
    noreq();
    rst = 1'b1;
    #1;
    check("rstrmw_wr_flag", bus.mem_write_flag, 1'b0);
    check("rstrmw_rd_flag", bus.mem_read_flag,  1'b0);
    check("rstrmw_ready",   bus.req_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("rstrmw_valid", bus.resp_valid, 1'b0);
    check("rstrmw_ready_after", bus.req_ready, 1'b1);
    check("rstrmw_mem", mem[12], 32'h01020304);
    req(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0); tick();
    check("rstrmw_readback", bus.resp_rdata, 32'h01020304);
    noreq();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
